// File: rtl/dff_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter in front of a single
// shared DFF storage register.
package dff_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LOCK_MAX = 16;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module dff_rr_picker
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Extra bit on sum so the wrap works for non-power-of-two NUM_REQ.
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any        = 1'b1;
        pick_idx   = cand;
        pick[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for one shared DATA_W-bit register, with an
// ownership lock and a watchdog that force-releases long-held locks.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           q,
  output logic [idx_w(NUM_REQ)-1:0]   q_owner,
  output logic                        q_valid,
  output logic                        locked,
  output logic                        timeout
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(LOCK_MAX);

  // Handshake: req[i] is a level held (with its wdata lane) until granted.
  // gnt[i] is combinational and one-hot; the lane is written into q at the
  // same rising edge, so there is no separate acknowledge.

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] lock_cnt;

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               any;
  logic [IDX_W-1:0]   commit_idx;
  logic               wr_en;
  logic [DATA_W-1:0]  lane [NUM_REQ];

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ-1)) ? '0 : i + IDX_W'(1);
  endfunction

  dff_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) lane[i] = wdata[i*DATA_W +: DATA_W];
  end

  always_comb begin
    gnt        = '0;
    commit_idx = (state == LOCKED) ? owner : pick_idx;
    if (rst_n) begin
      if (state == IDLE) gnt = pick;
      else               gnt[owner] = req[owner];
    end
    wr_en = |gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      q        <= '0;
      q_owner  <= '0;
      q_valid  <= 1'b0;
      locked   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (wr_en) begin
        q       <= lane[commit_idx];
        q_owner <= commit_idx;
        q_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any) begin
            rr_ptr <= wrap_inc(pick_idx);
            if (lock[pick_idx]) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              owner    <= pick_idx;
              lock_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (!lock[owner]) begin
            state    <= IDLE;
            locked   <= 1'b0;
            lock_cnt <= '0;
          end else if (lock_cnt == CNT_W'(LOCK_MAX-1)) begin
            // Watchdog: owner gets its final write this edge, then must re-compete.
            state    <= IDLE;
            locked   <= 1'b0;
            timeout  <= 1'b1;
            rr_ptr   <= wrap_inc(owner);
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: driver pushes expected grants into a
// queue, a negedge monitor pops them and checks gnt and the following q update.
module tb_dff_bank_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int LOCK_MAX = 4;
  localparam int E_W      = NUM_REQ + DATA_W;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         q;
  logic [1:0]                q_owner;
  logic                      q_valid;
  logic                      locked;
  logic                      timeout;

  int n_vec = 0;
  int n_err = 0;

  logic [E_W-1:0] exp_q[$];

  dff_bank_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .locked  (locked),
    .timeout (timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] g);
    int r = 0;
    for (int i = 0; i < NUM_REQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [DATA_W-1:0] d);
    wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_grant(input logic [NUM_REQ-1:0] g, input logic [DATA_W-1:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic              pend = 1'b0;
  logic [DATA_W-1:0] pend_data;
  int                pend_owner;

  always @(negedge clk) begin
    logic [E_W-1:0] e;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("q_data", 32'(q), 32'(pend_data));
        check("q_owner", 32'(q_owner), 32'(pend_owner));
        check("q_valid", 32'(q_valid), 32'd1);
        pend = 1'b0;
      end
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", 32'(gnt), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("gnt", 32'(gnt), 32'(e[E_W-1:DATA_W]));
          pend       = 1'b1;
          pend_data  = e[DATA_W-1:0];
          pend_owner = oh_idx(e[E_W-1:DATA_W]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    rst_n = 1'b0;
    req   = 4'hF;
    lock  = '0;
    wdata = '0;

    // 1: reset holds everything low even with all requests up
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_q_owner", 32'(q_owner), 32'd0);
    req   = '0;
    rst_n = 1'b1;
    step();
    step();
    check("idle_q", 32'(q), 32'd0);
    check("idle_q_valid", 32'(q_valid), 32'd0);

    // 2: single write from lane 2
    set_lane(2, 8'hA5);
    req = 4'b0100;
    expect_grant(4'b0100, 8'hA5);
    step();
    req = '0;
    step();
    step();

    // 3: fairness with all lanes requesting from rr_ptr=0
    do_reset();
    set_lane(0, 8'h10);
    set_lane(1, 8'h21);
    set_lane(2, 8'h32);
    set_lane(3, 8'h43);
    for (int k = 0; k < 8; k++) expect_grant(4'(1 << (k % 4)), 8'h10 + 8'((k % 4) * 8'h11));
    req = 4'hF;
    repeat (8) step();
    req = '0;
    step();

    // 4: lane 1 lock burst, lane 3 stalls until the lock drops
    set_lane(1, 8'hB1);
    set_lane(3, 8'hD3);
    req  = 4'b1010;
    lock = 4'b0010;
    repeat (3) expect_grant(4'b0010, 8'hB1);
    step();
    check("lock_locked", 32'(locked), 32'd1);
    step();
    step();
    req  = 4'b1000;
    lock = '0;
    #1;
    check("lock_stall_gnt", 32'(gnt), 32'd0);
    check("lock_still_locked", 32'(locked), 32'd1);
    expect_grant(4'b1000, 8'hD3);
    step();
    check("unlock_locked", 32'(locked), 32'd0);
    step();
    req = '0;
    step();

    // 5: watchdog: acquiring grant plus LOCK_MAX locked grants, then release
    do_reset();
    set_lane(0, 8'hC0);
    set_lane(1, 8'hE1);
    set_lane(2, 8'hE2);
    set_lane(3, 8'hE3);
    repeat (5) expect_grant(4'b0001, 8'hC0);
    expect_grant(4'b0010, 8'hE1);
    expect_grant(4'b0100, 8'hE2);
    expect_grant(4'b1000, 8'hE3);
    expect_grant(4'b0001, 8'hC0);
    req  = 4'hF;
    lock = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) begin
        check("wd_locked", 32'(locked), 32'd1);
        check("wd_no_timeout", 32'(timeout), 32'd0);
      end else begin
        check("wd_released", 32'(locked), 32'd0);
        check("wd_timeout", 32'(timeout), 32'd1);
      end
    end
    step();
    check("wd_timeout_pulse", 32'(timeout), 32'd0);
    step();
    step();
    step();
    req  = '0;
    lock = '0;
    check("wd_relocked", 32'(locked), 32'd1);
    step();
    check("wd_relock_drop", 32'(locked), 32'd0);
    step();

    // 6: reset in the middle of a lock
    set_lane(2, 8'h77);
    req  = 4'b0100;
    lock = 4'b0100;
    repeat (2) expect_grant(4'b0100, 8'h77);
    step();
    step();
    check("ml_locked", 32'(locked), 32'd1);
    check("ml_q", 32'(q), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("ml_rst_locked", 32'(locked), 32'd0);
    check("ml_rst_q", 32'(q), 32'd0);
    check("ml_rst_q_valid", 32'(q_valid), 32'd0);
    check("ml_rst_gnt", 32'(gnt), 32'd0);
    set_lane(0, 8'h5A);
    req  = 4'hF;
    lock = '0;
    step();
    step();
    rst_n = 1'b1;
    expect_grant(4'b0001, 8'h5A);
    step();
    req = '0;
    step();
    step();
    check("ml_after_locked", 32'(locked), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
